// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths, zero-register address and bypass selection (REGFILE_BYPASS_EN)
package reg_file_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif
endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: zero-register masking plus same-cycle write bypass when REGFILE_BYPASS_EN is defined
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] array_data,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data
);
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);
  logic hit;
  // $0 reads as zero; a pending write to the read address is forwarded only in bypass builds
  always_comb begin
    hit  = BYPASS_EN && write_enable && write_addr != ZERO && write_addr == addr;
    data = (addr == ZERO) ? '0 : hit ? write_data : array_data;
  end
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two combinational read ports, one write port, registered debug port; bypass via REGFILE_BYPASS_EN
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] RegAdd_rs,
  input  logic [ADDR_WIDTH-1:0] RegAdd_rt,
  output logic [DATA_WIDTH-1:0] RegData_rs,
  output logic [DATA_WIDTH-1:0] RegData_rt,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAdd,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] DebugAdd,
  output logic [DATA_WIDTH-1:0] DebugData,
  output logic [15:0]           WriteCount
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic write_ok;
  assign write_ok = WriteEnable && WriteAdd != ZERO;
  // reset clears everything and overrides a coincident write; debug reads pre-edge contents
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      DebugData  <= '0;
      WriteCount <= '0;
    end else begin
      if (write_ok) begin
        regs[WriteAdd] <= WriteData;
        WriteCount     <= WriteCount + 16'd1;
      end
      DebugData <= (DebugAdd == ZERO) ? '0 : regs[DebugAdd];
    end
  end
  reg_file_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rs (
    .addr(RegAdd_rs), .array_data(regs[RegAdd_rs]), .write_enable(WriteEnable),
    .write_addr(WriteAdd), .write_data(WriteData), .data(RegData_rs)
  );
  reg_file_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rt (
    .addr(RegAdd_rt), .array_data(regs[RegAdd_rt]), .write_enable(WriteEnable),
    .write_addr(WriteAdd), .write_data(WriteData), .data(RegData_rt)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file, expectations follow REGFILE_BYPASS_EN
module tb_reg_file;
  logic clock = 1'b0;
  logic reset;
  logic [4:0] RegAdd_rs, RegAdd_rt, WriteAdd, DebugAdd;
  logic [31:0] RegData_rs, RegData_rt, WriteData, DebugData;
  logic WriteEnable;
  logic [15:0] WriteCount;
  int total = 0;
  int passed = 0;
  always #5 clock = ~clock;
  reg_file dut (
    .clock(clock), .reset(reset), .RegAdd_rs(RegAdd_rs), .RegAdd_rt(RegAdd_rt),
    .RegData_rs(RegData_rs), .RegData_rt(RegData_rt), .WriteEnable(WriteEnable),
    .WriteAdd(WriteAdd), .WriteData(WriteData), .DebugAdd(DebugAdd),
    .DebugData(DebugData), .WriteCount(WriteCount)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    WriteEnable = 1'b1; WriteAdd = a; WriteData = d;
    tick();
    WriteEnable = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    RegAdd_rs = 5'd5;
    #1;
    total++; if (WriteCount !== 16'h0) $display("FAIL reset_count: got %h want %h", WriteCount, 16'h0); else passed++;
    total++; if (DebugData !== 32'h0) $display("FAIL reset_debug: got %h want %h", DebugData, 32'h0); else passed++;
    write_reg(5'd5, 32'hDEADBEEF);
    DebugAdd = 5'd5;
    #1;
    total++; if (RegData_rs !== 32'hDEADBEEF) $display("FAIL pre_reset_r5: got %h want %h", RegData_rs, 32'hDEADBEEF); else passed++;
    tick();
    total++; if (DebugData !== 32'hDEADBEEF) $display("FAIL debug_r5: got %h want %h", DebugData, 32'hDEADBEEF); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (RegData_rs !== 32'h0) $display("FAIL reset_r5: got %h want %h", RegData_rs, 32'h0); else passed++;
    total++; if (WriteCount !== 16'h0) $display("FAIL reset_count2: got %h want %h", WriteCount, 16'h0); else passed++;
    total++; if (DebugData !== 32'h0) $display("FAIL reset_debug2: got %h want %h", DebugData, 32'h0); else passed++;
  endtask
  task automatic test_write_read;
    write_reg(5'd31, 32'h12345678);
    RegAdd_rs = 5'd31; RegAdd_rt = 5'd31;
    #1;
    total++; if (RegData_rs !== 32'h12345678) $display("FAIL r31_rs: got %h want %h", RegData_rs, 32'h12345678); else passed++;
    total++; if (RegData_rt !== 32'h12345678) $display("FAIL r31_rt: got %h want %h", RegData_rt, 32'h12345678); else passed++;
    total++; if (WriteCount !== 16'd1) $display("FAIL count_one: got %h want %h", WriteCount, 16'd1); else passed++;
  endtask
  task automatic test_zero_reg;
    WriteEnable = 1'b1; WriteAdd = 5'd0; WriteData = 32'hFFFFFFFF; RegAdd_rs = 5'd0;
    #1;
    total++; if (RegData_rs !== 32'h0) $display("FAIL r0_same_cycle: got %h want %h", RegData_rs, 32'h0); else passed++;
    tick();
    WriteEnable = 1'b0;
    DebugAdd = 5'd0;
    #1;
    total++; if (RegData_rs !== 32'h0) $display("FAIL r0_after: got %h want %h", RegData_rs, 32'h0); else passed++;
    total++; if (WriteCount !== 16'd1) $display("FAIL r0_count: got %h want %h", WriteCount, 16'd1); else passed++;
    tick();
    total++; if (DebugData !== 32'h0) $display("FAIL r0_debug: got %h want %h", DebugData, 32'h0); else passed++;
  endtask
  task automatic test_hazard;
    logic [31:0] exp_rt;
`ifdef REGFILE_BYPASS_EN
    exp_rt = 32'hA5A5A5A5;
`else
    exp_rt = 32'h00000001;
`endif
    write_reg(5'd7, 32'h1);
    WriteEnable = 1'b1; WriteAdd = 5'd7; WriteData = 32'hA5A5A5A5; RegAdd_rt = 5'd7; DebugAdd = 5'd7;
    #1;
    total++; if (RegData_rt !== exp_rt) $display("FAIL hazard_same_cycle: got %h want %h", RegData_rt, exp_rt); else passed++;
    tick();
    WriteEnable = 1'b0;
    #1;
    total++; if (DebugData !== 32'h1) $display("FAIL hazard_debug_old: got %h want %h", DebugData, 32'h1); else passed++;
    total++; if (RegData_rt !== 32'hA5A5A5A5) $display("FAIL hazard_next_cycle: got %h want %h", RegData_rt, 32'hA5A5A5A5); else passed++;
    total++; if (WriteCount !== 16'd3) $display("FAIL hazard_count: got %h want %h", WriteCount, 16'd3); else passed++;
  endtask
  task automatic test_back_to_back;
    logic [31:0] vals [4] = '{32'h11111111, 32'h22222222, 32'hCAFEF00D, 32'h0BADC0DE};
    for (int i = 0; i < 4; i++) write_reg(5'(i + 10), vals[i]);
    for (int i = 0; i < 4; i += 2) begin
      RegAdd_rs = 5'(i + 10); RegAdd_rt = 5'(i + 11);
      #1;
      total++; if (RegData_rs !== vals[i]) $display("FAIL b2b_rs%0d: got %h want %h", i, RegData_rs, vals[i]); else passed++;
      total++; if (RegData_rt !== vals[i+1]) $display("FAIL b2b_rt%0d: got %h want %h", i, RegData_rt, vals[i+1]); else passed++;
    end
    total++; if (WriteCount !== 16'd7) $display("FAIL b2b_count: got %h want %h", WriteCount, 16'd7); else passed++;
  endtask
  task automatic test_reset_wins;
    write_reg(5'd3, 32'h99);
    reset = 1'b1; WriteEnable = 1'b1; WriteAdd = 5'd3; WriteData = 32'h55;
    tick();
    reset = 1'b0; WriteEnable = 1'b0; RegAdd_rs = 5'd3; DebugAdd = 5'd3;
    #1;
    total++; if (RegData_rs !== 32'h0) $display("FAIL reset_wins_r3: got %h want %h", RegData_rs, 32'h0); else passed++;
    total++; if (WriteCount !== 16'h0) $display("FAIL reset_wins_count: got %h want %h", WriteCount, 16'h0); else passed++;
    tick();
    total++; if (DebugData !== 32'h0) $display("FAIL reset_wins_debug: got %h want %h", DebugData, 32'h0); else passed++;
    write_reg(5'd3, 32'h77);
    #1;
    total++; if (RegData_rs !== 32'h77) $display("FAIL post_reset_write: got %h want %h", RegData_rs, 32'h77); else passed++;
  endtask
  task automatic test_wrap;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    WriteEnable = 1'b1; WriteAdd = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      WriteData = 32'(i);
      tick();
    end
    WriteEnable = 1'b0;
    #1;
    total++; if (WriteCount !== 16'hFFFF) $display("FAIL wrap_full: got %h want %h", WriteCount, 16'hFFFF); else passed++;
    write_reg(5'd1, 32'hBEEF0001);
    RegAdd_rs = 5'd1;
    #1;
    total++; if (WriteCount !== 16'h0000) $display("FAIL wrap_zero: got %h want %h", WriteCount, 16'h0000); else passed++;
    total++; if (RegData_rs !== 32'hBEEF0001) $display("FAIL wrap_r1: got %h want %h", RegData_rs, 32'hBEEF0001); else passed++;
  endtask
  initial begin
    reset = 1'b1; WriteEnable = 1'b0; WriteAdd = '0; WriteData = '0;
    RegAdd_rs = '0; RegAdd_rt = '0; DebugAdd = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_hazard();
    test_back_to_back();
    test_reset_wins();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
